// File: rtl/somador_subtrator_matrizes.sv
// somador_subtrator_matrizes: sequential TAMxTAM matrix add/subtract, VIAS elements per cycle,
// optional saturation, sticky overflow and start/done handshake.
module somador_subtrator_matrizes #(
  parameter int TAM     = 5,
  parameter int LARGURA = 8,
  parameter int VIAS    = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           iniciar,
  input  logic                           operacao,
  input  logic                           saturar,
  input  logic [TAM*TAM*LARGURA-1:0]     matriz_a,
  input  logic [TAM*TAM*LARGURA-1:0]     matriz_b,
  output logic [TAM*TAM*LARGURA-1:0]     matriz_resultado,
  output logic                           ocupado,
  output logic                           pronto,
  output logic                           overflow
);
  localparam int N      = TAM * TAM;
  localparam int W      = N * LARGURA;
  localparam int PASSOS = (N + VIAS - 1) / VIAS;
  localparam int CW     = PASSOS > 1 ? $clog2(PASSOS) : 1;
  localparam logic [LARGURA-1:0] MAXV = {1'b0, {(LARGURA-1){1'b1}}};
  localparam logic [LARGURA-1:0] MINV = {1'b1, {(LARGURA-1){1'b0}}};

  typedef enum logic [1:0] {OCIOSO, CALCULO, CONCLUIDO} estado_t;

  estado_t          r_estado;
  logic [CW-1:0]    r_passo;
  logic [W-1:0]     r_a, r_b, r_res;
  logic             r_op, r_sat, r_ocupado, r_pronto, r_ovf;
  logic [31:0]      w_idx [VIAS];
  logic [LARGURA-1:0] w_res [VIAS];
  logic [VIAS-1:0]  w_ok, w_ovf;

  // Lanes past the last element in a partial step are clamped to index 0 and masked by w_ok.
  for (genvar v = 0; v < VIAS; v++) begin : g_via
    logic [31:0]              w_i;
    logic [LARGURA-1:0]       w_ea, w_eb;
    logic signed [LARGURA:0]  w_x, w_y, w_s;
    assign w_i      = 32'(r_passo) * 32'(VIAS) + 32'(v);
    assign w_ok[v]  = w_i < 32'(N);
    assign w_idx[v] = w_ok[v] ? w_i : '0;
    assign w_ea     = r_a[w_idx[v]*LARGURA +: LARGURA];
    assign w_eb     = r_b[w_idx[v]*LARGURA +: LARGURA];
    assign w_x      = {w_ea[LARGURA-1], w_ea};
    assign w_y      = {w_eb[LARGURA-1], w_eb};
    assign w_s      = r_op ? w_x - w_y : w_x + w_y;
    assign w_ovf[v] = w_s[LARGURA] ^ w_s[LARGURA-1];
    assign w_res[v] = (w_ovf[v] && r_sat) ? (w_s[LARGURA] ? MINV : MAXV) : w_s[LARGURA-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_passo   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_op      <= 1'b0;
      r_sat     <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          r_pronto <= 1'b0;
          if (iniciar) begin
            r_a       <= matriz_a;
            r_b       <= matriz_b;
            r_op      <= operacao;
            r_sat     <= saturar;
            r_passo   <= '0;
            r_ovf     <= 1'b0;
            r_ocupado <= 1'b1;
            r_estado  <= CALCULO;
          end
        end
        CALCULO: begin
          for (int v = 0; v < VIAS; v++)
            if (w_ok[v]) r_res[w_idx[v]*LARGURA +: LARGURA] <= w_res[v];
          r_ovf <= r_ovf | |(w_ovf & w_ok);
          if (r_passo == CW'(PASSOS - 1)) begin
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b1;
            r_estado  <= CONCLUIDO;
          end else begin
            r_passo <= r_passo + 1'b1;
          end
        end
        CONCLUIDO: begin
          r_pronto <= 1'b0;
          r_estado <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign matriz_resultado = r_res;
  assign ocupado          = r_ocupado;
  assign pronto           = r_pronto;
  assign overflow         = r_ovf;
endmodule

// File: doc/somador_subtrator_matrizes.md
# somador_subtrator_matrizes

Sequential, parametrised matrix add/subtract unit for the coprocessor datapath. It computes A+B or A−B element-wise on two TAM×TAM matrices of signed LARGURA-bit elements, processing VIAS elements per clock. Unlike the earlier single-cycle combinational subtractor, it supports add or subtract mode, optional saturation, overflow reporting and a start/done handshake. It sits between the operand register file and the result bus, and is driven by the coprocessor control FSM.

## Interface
- TAM, default 5: matrix dimension (TAM×TAM elements), ≥1.
- LARGURA, default 8: element width in bits, signed two's complement, ≥2.
- VIAS, default 5: elements processed per cycle, 1..TAM*TAM.
- clk  in  1: clock, all state updates on the rising edge.
- rst_n  in  1: asynchronous active-low reset.
- iniciar  in  1: start request, sampled only in OCIOSO.
- operacao  in  1: 0 = A+B, 1 = A−B, latched with iniciar.
- saturar  in  1: 0 = wrap-around, 1 = saturate, latched with iniciar.
- matriz_a  in  TAM*TAM*LARGURA: operand A, flattened; element (coluna, linha) at bit offset LARGURA*(linha + TAM*coluna).
- matriz_b  in  TAM*TAM*LARGURA: operand B, same layout.
- matriz_resultado  out  TAM*TAM*LARGURA: registered result, same layout.
- ocupado  out  1: high while an operation is in progress.
- pronto  out  1: one-cycle pulse when the result is complete.
- overflow  out  1: set if any element overflowed in the last operation.

## Operation
- PASSOS = ceil(TAM*TAM / VIAS). Step counter width is clog2(PASSOS), minimum 1.
- FSM states:
  - OCIOSO: idle; iniciar=1 → CALCULO.
  - CALCULO: active for PASSOS cycles; after the final step → CONCLUIDO.
  - CONCLUIDO: one cycle; → OCIOSO.
- On acceptance of iniciar:
  - Latch matriz_a, matriz_b, operacao and saturar into internal registers.
  - Clear the step counter and overflow; set ocupado.
  - Input changes after acceptance have no effect on the operation.
- In CALCULO step k, lanes v=0..VIAS−1 handle element index i = k*VIAS+v:
  - If i < TAM*TAM, write that element's result into matriz_resultado.
  - Lanes with i ≥ TAM*TAM in the final partial step write nothing.
- Arithmetic: compute at LARGURA+1 bits signed.
  - Overflow occurs when the exact result is outside [−2^(LARGURA−1), 2^(LARGURA−1)−1].
  - saturar=0: keep the low LARGURA bits (wrap).
  - saturar=1: clamp to the nearest bound.
  - overflow is sticky within the operation and is set in both modes.
- CONCLUIDO: pronto=1, ocupado=0. matriz_resultado and overflow hold until the next accepted iniciar.
- iniciar while ocupado=1 or in CONCLUIDO is ignored; it is not queued.
- Elements not yet written in CALCULO keep their previous values. matriz_resultado is valid only from the pronto cycle onward.

## Timing
- Reset, asynchronous: FSM=OCIOSO, counter=0, matriz_resultado=0, ocupado=0, pronto=0, overflow=0, latched operands=0.
- Reset mid-operation aborts the operation immediately. No pronto is issued. After rst_n deassertion the unit is in OCIOSO and accepts iniciar on the first edge.
- iniciar sampled high at edge 0:
  - ocupado=1 from edge 0 through edge PASSOS.
  - Last element written at edge PASSOS.
  - pronto=1 for the single cycle after edge PASSOS (state CONCLUIDO), with ocupado=0.
  - Next iniciar is accepted at edge PASSOS+2 at the earliest. Throughput is one operation per PASSOS+2 cycles.
- pronto is never high for two consecutive cycles.
- Combinational path from inputs to outputs: none. All outputs are registered.

## Test plan
- Basic subtract (defaults, PASSOS=5): A all 10, B all 3, operacao=1, iniciar 1 cycle → pronto at cycle 6, all 25 elements = 7, overflow=0.
- Add with index check: A element i = i, B element i = 2i, operacao=0 → element i = 3i (i=0..24), e.g. (coluna 4, linha 4) = 72; overflow=0.
- Positive overflow: A[0]=127, B[0]=−1, subtract. saturar=0 → element 0 = −128, overflow=1. saturar=1 → element 0 = 127, overflow=1. Other elements unaffected.
- Negative saturation: A[24]=−128, B[24]=−128, add, saturar=1 → element 24 = −128, overflow=1. Same with saturar=0 → 0, overflow=1.
- Partial last step: VIAS=3, PASSOS=9, A all 1, B all 1, add → pronto at cycle 10, all 25 elements = 2.
- Protocol: iniciar pulsed again at cycle 2 with different operands → ignored, result from the first operands. Changing matriz_a mid-operation → no effect. rst_n low at cycle 3 → outputs 0 immediately, no pronto. A new iniciar after reset completes normally.
